fir_mac_engine: RTL and testbench

Sequential multiply-accumulate core of the FIR filter, sitting directly downstream of the word shift-register input stage. It accepts one input sample per valid/ready handshake and keeps the last TAPS samples in an internal circular history. For each accepted sample it computes the dot product with a programmable coefficient bank, one tap per clock, and presents the scaled result on a valid/ready output port.

---
 rtl/fir_mac_engine.sv | 144 ++++++++++++++
 tb/tb_fir_mac_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: sequential multiply-accumulate core of the FIR filter.
// Accepts one sample per in_valid/in_ready handshake, stores it in a circular
// history of TAPS entries and accumulates one coefficient*sample product per
// clock. The scaled result is offered on an out_valid/out_ready port.
// Optional build macro FIR_SATURATE_EN: clamp the result to the OUT_WIDTH
// range instead of wrapping it in two's complement.
module fir_mac_engine #(
  parameter int TAPS       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_BITS  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic                          coef_we,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic signed [COEF_WIDTH-1:0]  coef_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          busy
);

  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS);
  localparam int EXT_W = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t r_state, w_next;

  logic signed [DATA_WIDTH-1:0] r_hist [TAPS];
  logic signed [COEF_WIDTH-1:0] r_coef [TAPS];
  logic signed [ACC_W-1:0]      r_acc;
  logic [AW-1:0]                r_k;
  logic [AW-1:0]                r_wptr;
  logic [AW-1:0]                r_rd_idx;
  logic signed [OUT_WIDTH-1:0]  r_out;

  logic signed [ACC_W-1:0]      w_x_ext;
  logic signed [ACC_W-1:0]      w_c_ext;
  logic signed [ACC_W-1:0]      w_prod;
  logic signed [ACC_W-1:0]      w_acc_next;

  // Narrow the shifted accumulator to OUT_WIDTH (clamp or two's-complement wrap)
  function automatic logic signed [OUT_WIDTH-1:0] narrow(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SATURATE_EN
    logic signed [EXT_W-1:0] x;
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    x  = {{(EXT_W-ACC_W){a[ACC_W-1]}}, a};
    hi = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    lo = ~hi;
    if (x > hi)      x = hi;
    else if (x < lo) x = lo;
    return OUT_WIDTH'(x);
`else
    return OUT_WIDTH'(a);
`endif
  endfunction

  // Full-precision product of the current tap, sign-extended to the accumulator width
  always_comb begin
    w_x_ext    = {{(ACC_W-DATA_WIDTH){r_hist[r_rd_idx][DATA_WIDTH-1]}}, r_hist[r_rd_idx]};
    w_c_ext    = {{(ACC_W-COEF_WIDTH){r_coef[r_k][COEF_WIDTH-1]}}, r_coef[r_k]};
    w_prod     = w_x_ext * w_c_ext;
    w_acc_next = r_acc + w_prod;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and handshake outputs, decoded from state only
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (r_k == K_LAST) w_next = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // History, coefficient bank, accumulator and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= '0;
      end
      r_acc    <= '0;
      r_k      <= '0;
      r_wptr   <= '0;
      r_rd_idx <= '0;
      r_out    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Coefficients only change here, so one computation never mixes banks
          if (coef_we && (coef_addr <= K_LAST)) r_coef[coef_addr] <= coef_data;
          if (in_valid) begin
            r_hist[r_wptr] <= in_data;
            r_rd_idx       <= r_wptr;
            r_wptr         <= (r_wptr == K_LAST) ? '0 : r_wptr + 1'b1;
            r_acc          <= '0;
            r_k            <= '0;
          end
        end
        S_MAC: begin
          r_acc    <= w_acc_next;
          r_k      <= r_k + 1'b1;
          r_rd_idx <= (r_rd_idx == '0) ? K_LAST : r_rd_idx - 1'b1;
          // Last tap: latch the result including this cycle's product
          if (r_k == K_LAST) r_out <= narrow(w_acc_next >>> FRAC_BITS);
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: scoreboard bench for fir_mac_engine with TAPS=4.
// Stimulus pushes model results into a queue; a monitor pops them on each
// output handshake and also checks the accept-to-valid latency.
module tb_fir_mac_engine;

  localparam int TAPS = 4;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int OW   = 16;
  localparam int FRAC = 0;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 coef_we;
  logic [1:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic                 busy;

  fir_mac_engine #(
    .TAPS(TAPS), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .OUT_WIDTH(OW), .FRAC_BITS(FRAC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int v; int e; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hist_m [TAPS];   // hist_m[0] is the newest sample
  int coef_m [TAPS];
  bit ready_mode = 1'b0;
  bit ready_force = 1'b1;
  bit prev_vld = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Dot product of the last TAPS samples with the bank, then shift and narrow
  function automatic int model_y();
    longint acc;
    logic [OW-1:0] t;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(coef_m[k]) * longint'(hist_m[k]);
    acc = acc >>> FRAC;
`ifdef FIR_SATURATE_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
`else
    t = acc[OW-1:0];
    return int'($signed(t));
`endif
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist_m[k] = 0;
      coef_m[k] = 0;
    end
  endfunction

  // out_ready: random or forced, changed just after each rising edge
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) out_ready = 1'($urandom_range(0, 1));
      else            out_ready = ready_force;
    end
  end

  // Monitor: latency on rising out_valid, data on every output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_vld) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else               chk("latency", cyc, q[0].e + TAPS);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_handshake", 1, 0);
        else begin
          chk("out_data", int'(out_data), q[0].v);
          void'(q.pop_front());
        end
      end
      prev_vld = out_valid;
    end
  end

  // Offer a sample (optionally with a same-cycle coefficient write) until accepted
  task automatic send(input logic signed [DW-1:0] x, input bit we, input int addr, input int cv);
    int guard;
    logic signed [CW-1:0] c8;
    exp_t ex;
    bit ok;
    c8 = CW'(cv);
    in_valid = 1'b1; in_data = x;
    coef_we = we; coef_addr = 2'(addr); coef_data = c8;
    guard = 0; ok = 1'b0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      guard++;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      if (we) coef_m[addr] = int'(c8);
      for (int k = TAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
      hist_m[0] = int'(x);
      ex.v = model_y();
      ex.e = cyc + 1;
      q.push_back(ex);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  // Coefficient write while idle
  task automatic wcoef(input int addr, input int cv);
    int guard;
    logic signed [CW-1:0] c8;
    bit ok;
    c8 = CW'(cv);
    coef_we = 1'b1; coef_addr = 2'(addr); coef_data = c8;
    guard = 0; ok = 1'b0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      guard++;
    end
    if (!ok) chk("coef_idle_timeout", 0, 1);
    else     coef_m[addr] = int'(c8);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic set_bank(input int c0, input int c1, input int c2, input int c3);
    wcoef(0, c0); wcoef(1, c1); wcoef(2, c2); wcoef(3, c3);
  endtask

  initial begin
    int guard;
    int held;
    model_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(posedge clk); #1;

    // Impulse response with bank {1,2,3,4}
    set_bank(1, 2, 3, 4);
    send(8'sd1, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(8'sd0, 0, 0, 0);

    // Write while busy is ignored; write together with an accept is used
    send(8'sd5, 0, 0, 0);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd100;
    @(negedge clk);
    chk("busy_during_mac", int'(busy), 1);
    @(posedge clk); #1;
    coef_we = 1'b0;
    send(8'sd2, 0, 0, 0);
    send(8'sd3, 1, 0, 100);
    wcoef(0, 1);

    // Backpressure: result held, input not consumed
    ready_force = 1'b0;
    send(8'sd7, 0, 0, 0);
    guard = 0;
    while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
    chk("bp_reach_out", int'(out_valid), 1);
    held = q.size() > 0 ? q[0].v : 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'sd99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_data", int'(out_data), held);
      chk("bp_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ready_force = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (out_valid && guard < 50);
    chk("bp_release_idle", int'(in_ready), 1);
    @(posedge clk); #1;
    send(8'sd0, 0, 0, 0);
    send(8'sd0, 0, 0, 0);

    // Reset in the middle of a computation (k=2)
    send(8'sd9, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_busy", int'(busy), 0);
    if (q.size() > 0) void'(q.pop_back());
    model_reset();
    prev_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    set_bank(1, 2, 3, 4);
    send(8'sd1, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(8'sd0, 0, 0, 0);

    // Negative extremes and positive overflow
    set_bank(-128, -128, -128, -128);
    for (int i = 0; i < 4; i++) send(-8'sd128, 0, 0, 0);
    set_bank(127, 127, 127, 127);
    for (int i = 0; i < 4; i++) send(8'sd127, 0, 0, 0);

    // Random samples, random coefficient updates, random backpressure
    ready_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        send(DW'($urandom), 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      else
        send(DW'($urandom), 0, 0, 0);
    end

    // Drain
    ready_mode = 1'b0;
    ready_force = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 500) begin @(negedge clk); guard++; end
    chk("drain_left", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
